// File: rtl/reg_file_param_if.sv
// reg_file_param_if: decode/writeback bus into the parametrised register file.
interface reg_file_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] writedata;
    logic              write;
    logic              reserve;
    logic [ADDR_W-1:0] reserve_rd;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic              busy1;
    logic              busy2;
    logic              init_done;

    modport master (
        output rs1, rs2, rd, writedata, write, reserve, reserve_rd,
        input  reg1, reg2, busy1, busy2, init_done
    );
    modport slave (
        input  rs1, rs2, rd, writedata, write, reserve, reserve_rd,
        output reg1, reg2, busy1, busy2, init_done
    );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised 2R1W register file with bypass, busy scoreboard and post-reset clear.
module reg_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REG  = 16,
    parameter int ZERO_REG = 1
) (
    input logic             clock,
    input logic             reset,
    reg_file_param_if.slave bus
);
    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [ADDR_W:0]   NUM  = (ADDR_W+1)'(NUM_REG);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REG - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] regs [NUM_REG];
    logic [NUM_REG-1:0] busy;
    logic              wr_ok;
    logic              res_ok;

    function automatic logic valid(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NUM) && !(ZERO_REG != 0 && a == '0);
    endfunction

    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
        return !valid(a) ? '0 : (wr_ok && bus.rd == a) ? bus.writedata : regs[a];
    endfunction

    function automatic logic busy_val(input logic [ADDR_W-1:0] a);
        return valid(a) && busy[a] && !(wr_ok && bus.rd == a);
    endfunction

    always_comb begin
        wr_ok  = state == READY && bus.write && valid(bus.rd);
        res_ok = state == READY && bus.reserve && valid(bus.reserve_rd);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= CLEAR;
            idx           <= '0;
            busy          <= '0;
            bus.reg1      <= '0;
            bus.reg2      <= '0;
            bus.busy1     <= 1'b0;
            bus.busy2     <= 1'b0;
            bus.init_done <= 1'b0;
        end else if (state == CLEAR) begin
            idx       <= idx + 1'b1;
            bus.reg1  <= '0;
            bus.reg2  <= '0;
            bus.busy1 <= 1'b0;
            bus.busy2 <= 1'b0;
            if (idx == LAST) begin
                state         <= READY;
                bus.init_done <= 1'b1;
            end
        end else begin
            bus.reg1  <= rd_val(bus.rs1);
            bus.reg2  <= rd_val(bus.rs2);
            bus.busy1 <= busy_val(bus.rs1);
            bus.busy2 <= busy_val(bus.rs2);
            // a new reservation outranks a completing write to the same register
            for (int i = 0; i < NUM_REG; i++) begin
                if (res_ok && bus.reserve_rd == ADDR_W'(i))
                    busy[i] <= 1'b1;
                else if (wr_ok && bus.rd == ADDR_W'(i))
                    busy[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state == CLEAR)
            regs[idx] <= '0;
        else if (wr_ok)
            regs[bus.rd] <= bus.writedata;
    end
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed checks of reg_file_param with 16 and 12 implemented registers.
module tb_reg_file_param;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    reg_file_param_if #(.DATA_W(16), .ADDR_W(4)) a_if ();
    reg_file_param_if #(.DATA_W(16), .ADDR_W(4)) b_if ();

    reg_file_param #(.DATA_W(16), .ADDR_W(4), .NUM_REG(16), .ZERO_REG(1)) u_a (
        .clock(clock), .reset(reset), .bus(a_if.slave));
    reg_file_param #(.DATA_W(16), .ADDR_W(4), .NUM_REG(12), .ZERO_REG(1)) u_b (
        .clock(clock), .reset(reset), .bus(b_if.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_a();
        a_if.rs1 = '0; a_if.rs2 = '0; a_if.rd = '0; a_if.writedata = '0;
        a_if.write = 1'b0; a_if.reserve = 1'b0; a_if.reserve_rd = '0;
    endtask

    task automatic idle_b();
        b_if.rs1 = '0; b_if.rs2 = '0; b_if.rd = '0; b_if.writedata = '0;
        b_if.write = 1'b0; b_if.reserve = 1'b0; b_if.reserve_rd = '0;
    endtask

    initial begin
        idle_a();
        idle_b();
        step();
        step();
        chk("rst_reg1", a_if.reg1, 0);
        chk("rst_busy1", a_if.busy1, 0);
        chk("rst_init", a_if.init_done, 0);
        reset = 1'b0;
        a_if.rs1 = 4'd3;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("clr_init_a_%0d", i), a_if.init_done, (i == 16) ? 1 : 0);
            if (i == 11) chk("clr_init_b_11", b_if.init_done, 0);
            if (i == 12) chk("clr_init_b_12", b_if.init_done, 1);
            if (i < 16) chk($sformatf("clr_reg1_%0d", i), a_if.reg1, 0);
        end
        for (int i = 0; i < 16; i++) begin
            a_if.rs1 = 4'(i);
            a_if.rs2 = 4'(15 - i);
            step();
            chk($sformatf("zero_r1_%0d", i), a_if.reg1, 0);
            chk($sformatf("zero_r2_%0d", i), a_if.reg2, 0);
        end

        a_if.write = 1'b1; a_if.rd = 4'd3; a_if.writedata = 16'hBEEF; a_if.rs1 = 4'd3;
        step();
        chk("bypass_reg1", a_if.reg1, 16'hBEEF);
        a_if.write = 1'b0; a_if.rs2 = 4'd3;
        step();
        chk("array_reg2", a_if.reg2, 16'hBEEF);
        chk("array_reg1", a_if.reg1, 16'hBEEF);

        a_if.write = 1'b1; a_if.rd = 4'd0; a_if.writedata = 16'h1234; a_if.rs1 = 4'd0;
        step();
        chk("zero_bypass", a_if.reg1, 0);
        a_if.write = 1'b0; a_if.reserve = 1'b1; a_if.reserve_rd = 4'd0;
        step();
        chk("zero_read", a_if.reg1, 0);
        a_if.reserve = 1'b0;
        step();
        chk("zero_busy", a_if.busy1, 0);

        a_if.reserve = 1'b1; a_if.reserve_rd = 4'd5; a_if.rs1 = 4'd5; a_if.rs2 = 4'd5;
        step();
        chk("res_same_cycle", a_if.busy1, 0);
        a_if.reserve = 1'b0;
        step();
        chk("res_busy1", a_if.busy1, 1);
        chk("res_busy2", a_if.busy2, 1);
        a_if.write = 1'b1; a_if.rd = 4'd5; a_if.writedata = 16'h00A5;
        step();
        chk("wb_reg1", a_if.reg1, 16'h00A5);
        chk("wb_busy1", a_if.busy1, 0);
        a_if.write = 1'b0;
        step();
        chk("wb_busy_clr", a_if.busy1, 0);
        a_if.write = 1'b1; a_if.writedata = 16'h0055; a_if.reserve = 1'b1;
        step();
        a_if.write = 1'b0; a_if.reserve = 1'b0;
        step();
        chk("both_busy", a_if.busy1, 1);
        chk("both_data", a_if.reg1, 16'h0055);

        b_if.write = 1'b1; b_if.rd = 4'd14; b_if.writedata = 16'hFFFF; b_if.rs1 = 4'd14;
        b_if.reserve = 1'b1; b_if.reserve_rd = 4'd14;
        step();
        chk("oor_bypass", b_if.reg1, 0);
        b_if.write = 1'b0; b_if.reserve = 1'b0;
        step();
        chk("oor_reg1", b_if.reg1, 0);
        chk("oor_busy1", b_if.busy1, 0);
        for (int i = 0; i < 12; i++) begin
            b_if.rs1 = 4'(i);
            step();
            chk($sformatf("oor_keep_%0d", i), b_if.reg1, 0);
        end
        b_if.write = 1'b1; b_if.rd = 4'd11; b_if.writedata = 16'h0BBB;
        step();
        b_if.write = 1'b0;
        step();
        chk("top_reg_b", b_if.reg1, 16'h0BBB);

        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        step();
        chk("rst_mid_init", a_if.init_done, 0);
        reset = 1'b0;
        a_if.write = 1'b1; a_if.rd = 4'd9; a_if.writedata = 16'h7777;
        a_if.reserve = 1'b1; a_if.reserve_rd = 4'd10; a_if.rs1 = 4'd9; a_if.rs2 = 4'd10;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("reclr_init_%0d", i), a_if.init_done, (i == 16) ? 1 : 0);
            if (i < 16) chk($sformatf("reclr_busy2_%0d", i), a_if.busy2, 0);
        end
        idle_a();
        a_if.rs1 = 4'd9; a_if.rs2 = 4'd10;
        step();
        chk("ign_wr_data", a_if.reg1, 0);
        chk("ign_res_busy", a_if.busy2, 0);
        a_if.rs1 = 4'd3; a_if.rs2 = 4'd5;
        step();
        chk("reclr_r3", a_if.reg1, 0);
        chk("reclr_busy5", a_if.busy2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the 16x16 register file: configurable data width, address width and register count.
- Two registered read ports with write-to-read bypass and an optional hardwired zero register.
- Adds a per-register busy scoreboard so the decode stage can detect RAW hazards.
- Adds a post-reset clear sequencer that zeroes the whole array, one register per cycle.
- Sits between decode (rs1/rs2/reserve) and writeback (rd/writedata/write).

Parameters:
DATA_W, 16, register and data width in bits
ADDR_W, 4, register address width
NUM_REG, 16, implemented registers; must satisfy 2 <= NUM_REG <= 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
rs1  input  ADDR_W  read port 1 address
rs2  input  ADDR_W  read port 2 address
rd  input  ADDR_W  write address
writedata  input  DATA_W  write data
write  input  1  write enable
reserve  input  1  mark reserve_rd as pending (busy)
reserve_rd  input  ADDR_W  register to reserve
reg1  output  DATA_W  read data port 1, registered
reg2  output  DATA_W  read data port 2, registered
busy1  output  1  rs1 had a pending write when sampled, registered
busy2  output  1  rs2 had a pending write when sampled, registered
init_done  output  1  high once the clear sequence has completed

Behaviour:
- State machine has two states, CLEAR and READY. Reset forces CLEAR with clear index = 0.
- In CLEAR, each cycle writes 0 to regs[index] and increments index. When index = NUM_REG-1 is written, the next state is READY.
- Reset asserted on a cycle forces reg1=0, reg2=0, busy1=0, busy2=0, init_done=0, all busy bits=0 and state CLEAR at the next edge.
- Reset asserted mid-CLEAR restarts the clear at index 0.
- After reset deasserts: CLEAR lasts exactly NUM_REG cycles, then init_done=1 from the following cycle until the next reset.
- During CLEAR: write and reserve are ignored, and reg1/reg2/busy1/busy2 are held at 0.
- Reads in READY have 1-cycle latency. At each posedge, reg1 takes the first matching case, in priority order:
  - 0 if ZERO_REG=1 and rs1=0;
  - 0 if rs1 >= NUM_REG;
  - writedata if write=1, rd=rs1 and rd is writable (bypass);
  - regs[rs1] otherwise.
- reg2 follows the same rules using rs2.
- Writes: regs[rd] <= writedata when write=1, in READY, rd < NUM_REG, and not (ZERO_REG=1 and rd=0). Otherwise there is no effect.
- Scoreboard, per register, next value of busy bit i:
  - 1 if a valid reserve targets i;
  - else 0 if a valid write targets i;
  - else unchanged.
- Simultaneous reserve and write to the same register leaves it busy: the new producer wins.
- Reserve is valid when: READY, reserve_rd < NUM_REG, and not (ZERO_REG=1 and reserve_rd=0).
- busy1 is registered: busy[rs1] AND NOT (valid write to rs1 this cycle). A same-cycle reserve is not visible until the next cycle. busy2 follows the same rule for rs2.
- Out-of-range or zero-register addresses give busy1/busy2 = 0.
- Register contents are defined only after init_done=1.
- Writes take effect at the edge. A read of the same address one cycle later sees the new value via the array; a same-cycle read sees it via bypass.
- No arithmetic on data. Address comparisons use full ADDR_W width.

Test Plan:
- Reset held for 2 cycles, then released with NUM_REG=16 -> init_done=0 for exactly 16 cycles then 1; reading every register afterwards returns 0x0000.
- In READY: write=1, rd=3, writedata=0xBEEF, with rs1=3 in the same cycle -> reg1=0xBEEF next cycle (bypass). rs2=3 one cycle later -> reg2=0xBEEF.
- With ZERO_REG=1: write rd=0, writedata=0x1234, then read rs1=0 -> reg1=0x0000; reserve reserve_rd=0 -> busy1=0.
- Reserve r5, then read rs1=5 -> busy1=1. Write rd=5, 0x00A5 with rs1=5 in the same cycle -> reg1=0x00A5, busy1=0. Simultaneous reserve r5 + write r5 -> busy stays 1 on the next read.
- Reset asserted at clear index 7 -> clear restarts at 0, init_done rises 16 cycles after reset deasserts. Write and reserve issued during CLEAR leave no effect after init_done.
- With NUM_REG=12, ADDR_W=4: write rd=14, 0xFFFF, then read rs1=14 -> 0x0000, busy1=0, and regs 0..11 unchanged.
